// File: rtl/decode_queue.sv
// RV32I/E(+M) decode stage feeding a DEPTH-entry circular queue of decoded bundles.
// Illegal encodings are queued like any other and tagged for the trap logic downstream.
package core_package;
  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_JALR = 4'd10
  } alu_op_e;
endpackage

module decode_queue
  import core_package::*;
#(
  parameter int DEPTH    = 2,
  parameter int NUM_REGS = 32,
  parameter bit EN_M     = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [31:0]                  in_instr_i,
  input  logic [31:0]                  in_pc_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [31:0]                  out_pc_o,
  output logic [6:0]                   out_opcode_o,
  output alu_op_e                      out_alu_op_o,
  output logic [2:0]                   out_funct3_o,
  output logic [4:0]                   out_rd_o,
  output logic [4:0]                   out_rs1_o,
  output logic [4:0]                   out_rs2_o,
  output logic                         out_rd_we_o,
  output logic                         out_rs1_en_o,
  output logic                         out_rs2_en_o,
  output logic [31:0]                  out_imm_o,
  output logic                         out_muldiv_o,
  output logic                         out_illegal_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    alu_op_e     alu_op;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_we;
    logic        rs1_en;
    logic        rs2_en;
    logic [31:0] imm;
    logic        muldiv;
    logic        illegal;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          dec;
  entry_t          head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;

  assign opc = in_instr_i[6:0];
  assign f3  = in_instr_i[14:12];
  assign f7  = in_instr_i[31:25];

  assign imm_i = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
  assign imm_s = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
  assign imm_b = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7], in_instr_i[30:25],
                  in_instr_i[11:8], 1'b0};
  assign imm_u = {in_instr_i[31:12], 12'b0};
  assign imm_j = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12], in_instr_i[20],
                  in_instr_i[30:21], 1'b0};
  assign imm_z = {27'b0, in_instr_i[19:15]};

  function automatic alu_op_e alu_sel(input logic [2:0] fn3, input logic alt);
    case (fn3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc_i;
    dec.opcode = opc;
    dec.funct3 = f3;
    dec.rd     = in_instr_i[11:7];
    dec.rs1    = in_instr_i[19:15];
    dec.rs2    = in_instr_i[24:20];
    dec.alu_op = ALU_ADD;
    if (in_instr_i[1:0] != 2'b11) dec.illegal = 1'b1;
    case (opc)
      OPC_LOAD: begin
        dec.rs1_en = 1'b1; dec.rd_we = 1'b1; dec.imm = imm_i;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) dec.illegal = 1'b1;
      end
      OPC_STORE: begin
        dec.rs1_en = 1'b1; dec.rs2_en = 1'b1; dec.imm = imm_s;
        if (f3 > 3'd2) dec.illegal = 1'b1;
      end
      OPC_BRANCH: begin
        dec.rs1_en = 1'b1; dec.rs2_en = 1'b1; dec.imm = imm_b;
        if (f3 == 3'd2 || f3 == 3'd3) dec.illegal = 1'b1;
      end
      OPC_JALR: begin
        dec.rs1_en = 1'b1; dec.rd_we = 1'b1; dec.imm = imm_i; dec.alu_op = ALU_JALR;
        if (f3 != 3'd0) dec.illegal = 1'b1;
      end
      OPC_JAL: begin
        dec.rd_we = 1'b1; dec.imm = imm_j;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.rd_we = 1'b1; dec.imm = imm_u;
      end
      OPC_MISC_MEM: begin
        if (f3 > 3'd1) dec.illegal = 1'b1;
      end
      OPC_SYSTEM: begin
        dec.imm    = imm_z;
        dec.rs1_en = (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3);
        dec.rd_we  = (f3 != 3'd0);
        if (f3 == 3'd4) dec.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.rs1_en = 1'b1; dec.rd_we = 1'b1; dec.imm = imm_i;
        dec.alu_op = alu_sel(f3, (f3 == 3'd5) && f7[5]);
        if (f3 == 3'd1 && f7 != 7'b0000000) dec.illegal = 1'b1;
        if (f3 == 3'd5 && f7 != 7'b0000000 && f7 != 7'b0100000) dec.illegal = 1'b1;
      end
      OPC_OP: begin
        dec.rs1_en = 1'b1; dec.rs2_en = 1'b1; dec.rd_we = 1'b1;
        if (f7 == 7'b0000000) dec.alu_op = alu_sel(f3, 1'b0);
        else if (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) dec.alu_op = alu_sel(f3, 1'b1);
        else if (f7 == 7'b0000001 && EN_M) dec.muldiv = 1'b1;
        else dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // RV32E: only indices that are actually used count against the 16-register limit
    if (NUM_REGS == 16 && ((dec.rd_we && dec.rd[4]) || (dec.rs1_en && dec.rs1[4]) ||
                           (dec.rs2_en && dec.rs2[4])))
      dec.illegal = 1'b1;
    if (dec.illegal) begin
      dec.rd_we  = 1'b0;
      dec.rs1_en = 1'b0;
      dec.rs2_en = 1'b0;
      dec.muldiv = 1'b0;
      dec.alu_op = ALU_ADD;
    end
  end

  assign in_ready_o  = (count < CW'(DEPTH));
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign count_o     = count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '{default: '0};
    end else if (flush_i) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign head          = mem[rd_ptr];
  assign out_pc_o      = head.pc;
  assign out_opcode_o  = head.opcode;
  assign out_alu_op_o  = head.alu_op;
  assign out_funct3_o  = head.funct3;
  assign out_rd_o      = head.rd;
  assign out_rs1_o     = head.rs1;
  assign out_rs2_o     = head.rs2;
  assign out_rd_we_o   = head.rd_we;
  assign out_rs1_en_o  = head.rs1_en;
  assign out_rs2_en_o  = head.rs2_en;
  assign out_imm_o     = head.imm;
  assign out_muldiv_o  = head.muldiv;
  assign out_illegal_o = head.illegal;

endmodule
